rate_timer: RTL and testbench
=============================

# rate_timer

Programmable tick generator that consumes the 7-bit one-hot rate code produced by the speed shifter and turns it into a periodic one-cycle `tick` pulse plus a square-wave `toggle` level for the display/LED path. Bit k of the code selects a period of `BASE_PERIOD << k` clock cycles, so bit 0 is the fastest rate and bit 6 the slowest. It sits directly downstream of the shifter and upstream of the display logic, and it keeps running cleanly across rate changes.

## Interface
- `BASE_PERIOD`, 1000: period in cycles for code bit 0. Legal range is 1 and up; `BASE_PERIOD << 6` must fit in `CNT_W`.
- `CNT_W`, 16: width of the down-counter.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: reset, **asynchronous, active-low**. Asserted while 0.
- `enable` input 1: counting enable. When low, the count pauses.
- `rate` input 7: one-hot rate code from the shifter. Bit k gives period P = `BASE_PERIOD << k`.
- `tick` output 1: registered pulse, high for exactly one cycle per period.
- `toggle` output 1: registered level that inverts on every tick.
- `code_err` output 1: only present with `RATE_TIMER_ERR_EN` (see Configuration).

## Operation
- State registers:
  - `cnt` [CNT_W]
  - `rate_q` [7]: last accepted valid code
  - `tick`
  - `toggle`
- Valid code: exactly one bit of `rate` set. Zero and multi-hot codes are invalid and are ignored; `rate_q` holds its value.
- Period is derived from `rate_q` only: P = `BASE_PERIOD << index(rate_q)`.
- Per rising edge, in priority order:
  1. `rate` valid and != `rate_q`: `rate_q`<=`rate`, `cnt`<=P_new-1, `tick`<=0. Applies regardless of `enable`. The interrupted period is discarded and no tick is produced.
  2. `enable`=0: `cnt` holds, `tick`<=0, `toggle` holds.
  3. `cnt`==0: `cnt`<=P-1, `tick`<=1, `toggle`<=~`toggle`.
  4. Otherwise: `cnt`<=`cnt`-1, `tick`<=0.
- No arithmetic wrap is permitted. `cnt` never decrements below 0; it is reloaded instead.
- `BASE_PERIOD`=1 with bit 0 selected gives `tick` high every cycle and `toggle` alternating every cycle.

## Timing
- Reset values (async, immediately while `reset`=0):
  - `cnt`=`BASE_PERIOD`-1
  - `rate_q`=7'b0000001
  - `tick`=0
  - `toggle`=0
  - `code_err`=0
- After reset release, with `enable`=1 and a constant valid `rate` equal to 7'b0000001, `tick` first goes high in the cycle following the P-th rising edge. Ticks then recur every P cycles exactly.
- After a rate change is accepted at edge E, the first new tick appears in the cycle following edge E+P_new (assuming `enable` stays high).
- `enable` low for N cycles delays the next tick by exactly N cycles. The partial count is preserved.
- `tick` and `toggle` change only on clock edges; both are glitch-free register outputs.
- Reset asserted mid-period: all state returns to reset values asynchronously. The prior `rate_q` is lost until the next valid code differs from 7'b0000001.
- An invalid code on `rate` has no effect on timing.

## Configuration
- `RATE_TIMER_ERR_EN` defined:
  - Adds output `code_err`, registered.
  - `code_err` is 1 in the cycle after any edge where `rate` is invalid; otherwise 0.
  - Reset value is 0.
- `RATE_TIMER_ERR_EN` undefined:
  - `code_err` port and logic are absent.
  - Invalid codes are silently ignored.
  - All other behaviour is identical.

## Test plan
All scenarios use `BASE_PERIOD`=4 and `CNT_W`=16.
- **Reset and base rate:** release `reset`, `enable`=1, `rate`=7'b0000001 -> `tick` high 1 cycle every 4 cycles, first after the 4th edge; `toggle` inverts with each tick; `tick`=`toggle`=0 during reset.
- **Slowest rate:** `rate`=7'b1000000 -> tick spacing 256 cycles; counter does not overflow.
- **Mid-period change:** 2 cycles into a bit-0 period, set `rate`=7'b0000100 -> no tick from the old period; next tick 16 cycles after the change edge, then every 16.
- **Pause:** `enable`=0 for 5 cycles mid-period at bit 1 (P=8) -> that tick is delayed by exactly 5 cycles; `toggle` is unchanged during the pause.
- **Invalid codes:** drive 7'b0000000, then 7'b0011000, while at bit 2 -> period stays 16; with `RATE_TIMER_ERR_EN`, `code_err`=1 for each such cycle.
- **Async reset:** assert `reset`=0 between edges mid-count at bit 3 -> outputs clear immediately; after release, period returns to 4.

Source files
------------

// File: rtl/rate_timer_if.sv
// rtl/rate_timer_if.sv - rate/enable inputs and tick/toggle outputs of rate_timer
//
// Signals:
//   enable   : counting enable (driven by master)
//   rate     : 7-bit one-hot rate code (driven by master)
//   tick     : one-cycle pulse per period (driven by slave)
//   toggle   : square-wave level, inverts on every tick (driven by slave)
//   code_err : invalid-code flag, only with RATE_TIMER_ERR_EN (driven by slave)
interface rate_timer_if;
    logic       enable;
    logic [6:0] rate;
    logic       tick;
    logic       toggle;
`ifdef RATE_TIMER_ERR_EN
    logic       code_err;

    modport master (output enable, output rate, input tick, input toggle, input code_err);
    modport slave  (input enable, input rate, output tick, output toggle, output code_err);
`else
    modport master (output enable, output rate, input tick, input toggle);
    modport slave  (input enable, input rate, output tick, output toggle);
`endif
endinterface

// File: rtl/rate_timer.sv
// rtl/rate_timer.sv - one-hot rate code to periodic tick pulse and toggle level
//
// Parameters:
//   BASE_PERIOD : period in cycles for rate bit 0 (>= 1)
//   CNT_W       : down-counter width; BASE_PERIOD << 6 must fit
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : rate_timer_if.slave (enable, rate in; tick, toggle, [code_err] out)
// Optional feature macro: RATE_TIMER_ERR_EN adds the registered code_err output.
module rate_timer #(
    parameter int BASE_PERIOD = 1000,
    parameter int CNT_W       = 16
) (
    input  logic         clk,
    input  logic         reset,
    rate_timer_if.slave  bus
);

    logic [CNT_W-1:0] cnt;
    logic [6:0]       rate_q;
    logic             tick_q;
    logic             toggle_q;
    logic             rate_valid;
    logic [CNT_W-1:0] period_cur;
    logic [CNT_W-1:0] period_new;

    // Period for a one-hot code; a zero code falls back to the base period,
    // though callers only ever pass valid codes.
    function automatic logic [CNT_W-1:0] period_of(input logic [6:0] code);
        logic [CNT_W-1:0] p;
        p = CNT_W'(BASE_PERIOD);
        for (int k = 0; k < 7; k++) begin
            if (code[k]) begin
                p = CNT_W'(BASE_PERIOD) << k;
            end
        end
        return p;
    endfunction

    // One-hot test: nonzero and clearing the lowest set bit leaves nothing.
    assign rate_valid = (bus.rate != 7'd0) && ((bus.rate & (bus.rate - 7'd1)) == 7'd0);
    assign period_cur = period_of(rate_q);
    assign period_new = period_of(bus.rate);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt      <= CNT_W'(BASE_PERIOD - 1);
            rate_q   <= 7'b0000001;
            tick_q   <= 1'b0;
            toggle_q <= 1'b0;
        end else if (rate_valid && (bus.rate != rate_q)) begin
            // A new rate restarts the period immediately, even while paused;
            // the interrupted period produces no tick.
            rate_q <= bus.rate;
            cnt    <= period_new - CNT_W'(1);
            tick_q <= 1'b0;
        end else if (!bus.enable) begin
            tick_q <= 1'b0;
        end else if (cnt == '0) begin
            cnt      <= period_cur - CNT_W'(1);
            tick_q   <= 1'b1;
            toggle_q <= ~toggle_q;
        end else begin
            cnt    <= cnt - CNT_W'(1);
            tick_q <= 1'b0;
        end
    end

    assign bus.tick   = tick_q;
    assign bus.toggle = toggle_q;

`ifdef RATE_TIMER_ERR_EN
    logic code_err_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            code_err_q <= 1'b0;
        end else begin
            code_err_q <= ~rate_valid;
        end
    end

    assign bus.code_err = code_err_q;
`endif

endmodule

// File: tb/tb_rate_timer.sv
// tb/tb_rate_timer.sv - directed self-checking bench for rate_timer (BASE_PERIOD=4)
module tb_rate_timer;

    logic clk;
    logic reset;
    int   tests;
    int   failed;
    int   n;
    logic exp_tgl;

    rate_timer_if bus ();

    rate_timer #(
        .BASE_PERIOD (4),
        .CNT_W       (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, ending 1 time unit after the last one.
    task automatic step(input int cycles);
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Count edges until tick is seen high after one; bounded by limit.
    task automatic run_until_tick(input int limit, output int edges);
        edges = 0;
        while (edges < limit) begin
            @(posedge clk);
            #1;
            edges++;
            if (bus.tick === 1'b1) break;
        end
    endtask

    initial begin
        tests   = 0;
        failed  = 0;
        exp_tgl = 1'b0;
        reset      = 1'b0;
        bus.enable = 1'b1;
        bus.rate   = 7'b0000001;

        // Reset state, including across edges while held in reset
        #3;
        chk("rst_tick", 32'(bus.tick), 0);
        chk("rst_toggle", 32'(bus.toggle), 0);
`ifdef RATE_TIMER_ERR_EN
        chk("rst_code_err", 32'(bus.code_err), 0);
`endif
        step(2);
        chk("rst_hold_tick", 32'(bus.tick), 0);
        chk("rst_hold_toggle", 32'(bus.toggle), 0);

        // Base rate: first tick after the 4th edge, then every 4
        #4 reset = 1'b1;
        run_until_tick(20, n);
        exp_tgl = ~exp_tgl;
        chk("base_first", 32'(n), 4);
        chk("base_toggle1", 32'(bus.toggle), 32'(exp_tgl));
        step(1);
        chk("base_tick_one_cycle", 32'(bus.tick), 0);
        run_until_tick(20, n);
        exp_tgl = ~exp_tgl;
        chk("base_second", 32'(n), 3);
        chk("base_toggle2", 32'(bus.toggle), 32'(exp_tgl));

        // Slowest rate: 256-cycle spacing
        bus.rate = 7'b1000000;
        run_until_tick(300, n);
        exp_tgl = ~exp_tgl;
        chk("slow_first", 32'(n), 257);
        run_until_tick(300, n);
        exp_tgl = ~exp_tgl;
        chk("slow_period", 32'(n), 256);
        chk("slow_toggle", 32'(bus.toggle), 32'(exp_tgl));

        // Mid-period change from bit 0 to bit 2
        bus.rate = 7'b0000001;
        run_until_tick(20, n);
        exp_tgl = ~exp_tgl;
        chk("mid_bit0", 32'(n), 5);
        step(2);
        chk("mid_no_tick", 32'(bus.tick), 0);
        bus.rate = 7'b0000100;
        run_until_tick(40, n);
        exp_tgl = ~exp_tgl;
        chk("mid_first_new", 32'(n), 17);
        run_until_tick(40, n);
        exp_tgl = ~exp_tgl;
        chk("mid_period_new", 32'(n), 16);
        chk("mid_toggle", 32'(bus.toggle), 32'(exp_tgl));

        // Pause for 5 cycles mid-period at bit 1
        bus.rate = 7'b0000010;
        run_until_tick(30, n);
        exp_tgl = ~exp_tgl;
        chk("pause_setup", 32'(n), 9);
        step(3);
        bus.enable = 1'b0;
        step(5);
        chk("pause_tick", 32'(bus.tick), 0);
        chk("pause_toggle", 32'(bus.toggle), 32'(exp_tgl));
        bus.enable = 1'b1;
        run_until_tick(30, n);
        exp_tgl = ~exp_tgl;
        chk("pause_resume", 32'(n), 5);
        chk("pause_toggle_after", 32'(bus.toggle), 32'(exp_tgl));

        // Invalid codes while at bit 2
        bus.rate = 7'b0000100;
        run_until_tick(40, n);
        exp_tgl = ~exp_tgl;
        chk("inv_setup", 32'(n), 17);
        bus.rate = 7'b0000000;
        step(2);
`ifdef RATE_TIMER_ERR_EN
        chk("inv_err_zero", 32'(bus.code_err), 1);
`endif
        bus.rate = 7'b0011000;
        step(2);
`ifdef RATE_TIMER_ERR_EN
        chk("inv_err_multi", 32'(bus.code_err), 1);
`endif
        bus.rate = 7'b0000100;
        step(1);
        chk("inv_no_tick", 32'(bus.tick), 0);
`ifdef RATE_TIMER_ERR_EN
        chk("inv_err_clear", 32'(bus.code_err), 0);
`endif
        run_until_tick(40, n);
        exp_tgl = ~exp_tgl;
        chk("inv_period_kept", 32'(n), 11);

        // Async reset mid-count at bit 3, then base period again
        bus.rate = 7'b0001000;
        run_until_tick(60, n);
        exp_tgl = ~exp_tgl;
        chk("ares_setup", 32'(n), 33);
        run_until_tick(60, n);
        exp_tgl = ~exp_tgl;
        chk("ares_period", 32'(n), 32);
        chk("ares_toggle_pre", 32'(bus.toggle), 32'(exp_tgl));
        step(5);
        #2 reset = 1'b0;
        #1;
        chk("ares_tick", 32'(bus.tick), 0);
        chk("ares_toggle", 32'(bus.toggle), 0);
        bus.rate = 7'b0000001;
        exp_tgl  = 1'b0;
        #2 reset = 1'b1;
        run_until_tick(20, n);
        exp_tgl = ~exp_tgl;
        chk("ares_base_first", 32'(n), 4);
        run_until_tick(20, n);
        exp_tgl = ~exp_tgl;
        chk("ares_base_period", 32'(n), 4);
        chk("ares_base_toggle", 32'(bus.toggle), 32'(exp_tgl));

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
